// File: rtl/marquee_scroll_param_if.sv
// Load-port bundle for the marquee message buffer: requester drives the write,
// the marquee answers with a registered ready.
interface marquee_scroll_param_if #(
  parameter int IDX_W = 3,
  parameter int SEG_W = 7
);
  logic             LD_VALID;
  logic             LD_READY;
  logic [IDX_W-1:0] LD_INDEX;
  logic [SEG_W-1:0] LD_CHAR;

  modport master (output LD_VALID, output LD_INDEX, output LD_CHAR, input LD_READY);
  modport slave  (input LD_VALID, input LD_INDEX, input LD_CHAR, output LD_READY);
endinterface

// File: rtl/marquee_scroll_param.sv
// Parametrised multiplexed 7-segment marquee: writable message buffer, scrolling
// window (rotate/bounce/hold/blink) and a common-anode digit scanner.
module marquee_scroll_param #(
  parameter int               NUM_DIGITS  = 4,
  parameter int               MSG_CHARS   = 8,
  parameter int               SEG_W       = 7,
  parameter int               TICK_DIV    = 12500000,
  parameter int               REFRESH_DIV = 250000,
  parameter logic [SEG_W-1:0] BLANK       = {SEG_W{1'b1}},
  localparam int              IDX_W       = (MSG_CHARS > 1) ? $clog2(MSG_CHARS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  DIR,
  input  logic [1:0]            MODE,
  input  logic [1:0]            SPEED,
  marquee_scroll_param_if.slave ld,
  output logic [SEG_W-1:0]      DISP,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [IDX_W-1:0]      POS,
  output logic                  WRAP
);
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CNT_W = $clog2(4 * TICK_DIV) + 1;
  localparam int SUM_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(MSG_CHARS - 1);
  localparam logic [IDX_W-1:0] B_HI = IDX_W'(MSG_CHARS - NUM_DIGITS);

  typedef enum logic [1:0] {M_ROTATE = 2'b00, M_BOUNCE = 2'b01, M_HOLD = 2'b10, M_BLINK = 2'b11} mode_e;
  typedef enum logic {B_FWD = 1'b0, B_BWD = 1'b1} bdir_e;

  mode_e                 mode_s;
  logic [SEG_W-1:0]      msg_r [MSG_CHARS];
  logic [IDX_W-1:0]      ptr_r, ptr_nxt_s;
  logic [CNT_W-1:0]      step_cnt_r, per_m1_s;
  logic                  tick_s, wrap_r, wrap_nxt_s, blank_r, blank_nxt_s;
  logic                  ld_ready_r, wr_s, scan_term_s;
  bdir_e                 bdir_r, bdir_nxt_s;
  logic [SC_W-1:0]       scan_cnt_r;
  logic [DIG_W-1:0]      digit_r;
  logic [SUM_W-1:0]      sum_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic [SEG_W-1:0]      disp_r;
  logic [NUM_DIGITS-1:0] an_r;

  assign mode_s      = mode_e'(MODE);
  assign tick_s      = EN && (step_cnt_r >= per_m1_s);
  assign wr_s        = ld.LD_VALID && ld_ready_r && ({1'b0, ld.LD_INDEX} < SUM_W'(MSG_CHARS));
  assign scan_term_s = (scan_cnt_r == SC_W'(REFRESH_DIV - 1));

  // Step period selection (period minus one, compared with >= so a shorter period fires at once)
  always_comb begin
    per_m1_s = CNT_W'(TICK_DIV - 1);
    case (SPEED)
      2'd0:    per_m1_s = CNT_W'(TICK_DIV - 1);
      2'd1:    per_m1_s = CNT_W'(2 * TICK_DIV - 1);
      2'd2:    per_m1_s = CNT_W'(3 * TICK_DIV - 1);
      2'd3:    per_m1_s = CNT_W'(4 * TICK_DIV - 1);
      default: per_m1_s = CNT_W'(TICK_DIV - 1);
    endcase
  end

  // Step counter, frozen while EN is low
  always_ff @(posedge CLK) begin
    if (RST)         step_cnt_r <= '0;
    else if (tick_s) step_cnt_r <= '0;
    else if (EN)     step_cnt_r <= step_cnt_r + CNT_W'(1);
    else             step_cnt_r <= step_cnt_r;
  end

  // Window pointer, bounce direction, blink phase and wrap next-state
  always_comb begin
    ptr_nxt_s   = ptr_r;
    wrap_nxt_s  = 1'b0;
    bdir_nxt_s  = bdir_r;
    blank_nxt_s = (mode_s == M_BLINK) ? blank_r : 1'b0;
    if (tick_s) begin
      case (mode_s)
        M_ROTATE: begin
          if (DIR == 1'b0) begin
            if (ptr_r == LAST) begin
              ptr_nxt_s  = '0;
              wrap_nxt_s = 1'b1;
            end else begin
              ptr_nxt_s = ptr_r + IDX_W'(1);
            end
          end else begin
            if (ptr_r == '0) begin
              ptr_nxt_s  = LAST;
              wrap_nxt_s = 1'b1;
            end else begin
              ptr_nxt_s = ptr_r - IDX_W'(1);
            end
          end
        end
        M_BOUNCE: begin
          // A pointer left above the stop by rotate mode also counts as an end stop
          if (B_HI == '0) begin
            ptr_nxt_s  = '0;
            wrap_nxt_s = 1'b1;
          end else if (bdir_r == B_FWD) begin
            if (ptr_r >= B_HI) begin
              ptr_nxt_s  = ptr_r - IDX_W'(1);
              bdir_nxt_s = B_BWD;
              wrap_nxt_s = 1'b1;
            end else begin
              ptr_nxt_s = ptr_r + IDX_W'(1);
            end
          end else begin
            if (ptr_r == '0) begin
              ptr_nxt_s  = IDX_W'(1);
              bdir_nxt_s = B_FWD;
              wrap_nxt_s = 1'b1;
            end else begin
              ptr_nxt_s = ptr_r - IDX_W'(1);
            end
          end
        end
        M_BLINK: blank_nxt_s = ~blank_r;
        default: ptr_nxt_s = ptr_r;
      endcase
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Window state and load-ready registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_r      <= '0;
      wrap_r     <= 1'b0;
      bdir_r     <= B_FWD;
      blank_r    <= 1'b0;
      ld_ready_r <= 1'b0;
    end else begin
      ptr_r      <= ptr_nxt_s;
      wrap_r     <= wrap_nxt_s;
      bdir_r     <= bdir_nxt_s;
      blank_r    <= blank_nxt_s;
      ld_ready_r <= !EN || (mode_s == M_HOLD);
    end
  end

  // Message buffer; out-of-range indices are handshaken but dropped by wr_s
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < MSG_CHARS; i++) msg_r[i] <= BLANK;
    end else if (wr_s) begin
      msg_r[ld.LD_INDEX] <= ld.LD_CHAR;
    end else begin
      msg_r <= msg_r;
    end
  end

  // Digit i shows buf[(ptr + NUM_DIGITS-1-i) mod MSG_CHARS]; the sum stays below 2*MSG_CHARS
  always_comb begin
    sum_s    = SUM_W'(ptr_r) + SUM_W'(NUM_DIGITS - 1) - SUM_W'(digit_r);
    rd_idx_s = (sum_s >= SUM_W'(MSG_CHARS)) ? IDX_W'(sum_s - SUM_W'(MSG_CHARS)) : IDX_W'(sum_s);
  end

  // Digit scanner: AN and DISP latch together at the end of each scan slot
  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_cnt_r <= '0;
      digit_r    <= DIG_W'(NUM_DIGITS - 1);
      an_r       <= '1;
      disp_r     <= BLANK;
    end else if (scan_term_s) begin
      scan_cnt_r <= '0;
      digit_r    <= (digit_r == '0) ? DIG_W'(NUM_DIGITS - 1) : digit_r - DIG_W'(1);
      an_r       <= ~(NUM_DIGITS'(1) << digit_r);
      disp_r     <= blank_r ? BLANK : msg_r[rd_idx_s];
    end else begin
      scan_cnt_r <= scan_cnt_r + SC_W'(1);
      digit_r    <= digit_r;
      an_r       <= an_r;
      disp_r     <= disp_r;
    end
  end

  assign DISP        = disp_r;
  assign AN          = an_r;
  assign POS         = ptr_r;
  assign WRAP        = wrap_r;
  assign ld.LD_READY = ld_ready_r;
endmodule

// File: tb/tb_marquee_scroll_param.sv
// Scoreboard bench for marquee_scroll_param: a behavioural model pushes expected
// outputs per clock, a monitor pops and compares; directed checks cover the plan.
module tb_marquee_scroll_param;
  localparam int N = 4, M = 6, TD = 4, RD = 2;

  logic       CLK = 1'b0;
  logic       RST, EN, DIR;
  logic [1:0] MODE, SPEED;
  logic [6:0] DISP;
  logic [3:0] AN;
  logic [2:0] POS;
  logic       WRAP;

  marquee_scroll_param_if #(.IDX_W(3), .SEG_W(7)) ld_if ();

  marquee_scroll_param #(
    .NUM_DIGITS(N), .MSG_CHARS(M), .SEG_W(7), .TICK_DIV(TD), .REFRESH_DIV(RD), .BLANK(7'h7F)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DIR(DIR), .MODE(MODE), .SPEED(SPEED),
    .ld(ld_if), .DISP(DISP), .AN(AN), .POS(POS), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  typedef struct {
    int an; int disp; int pos; int wrap; int rdy; bit rdy_known;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state, in spec terms
  int m_buf[M];
  int m_ptr, m_elapsed, m_edges, m_an, m_disp, m_wrap, m_rdy;
  bit m_fwd, m_visible, m_rdy_known, m_live = 1'b0;

  always @(posedge CLK) begin : model
    int   digit, per;
    bit   tick;
    exp_t e;
    if (RST) begin
      foreach (m_buf[i]) m_buf[i] = 'h7F;
      m_ptr = 0; m_elapsed = 0; m_edges = 0; m_an = 'hF; m_disp = 'h7F; m_wrap = 0;
      m_fwd = 1'b1; m_visible = 1'b1; m_rdy = 0; m_rdy_known = 1'b0; m_live = 1'b1;
    end else if (m_live) begin
      // scan slot ends every RD cycles, digits visited N-1 down to 0
      if (m_edges % RD == RD - 1) begin
        digit  = (N - 1) - ((m_edges / RD) % N);
        m_an   = 15 ^ (1 << digit);
        m_disp = m_visible ? m_buf[(m_ptr + N - 1 - digit) % M] : 'h7F;
      end
      m_edges++;
      if (ld_if.LD_VALID && m_rdy_known && m_rdy == 1 && int'(ld_if.LD_INDEX) < M)
        m_buf[ld_if.LD_INDEX] = int'(ld_if.LD_CHAR);
      per  = (int'(SPEED) + 1) * TD;
      tick = EN && (m_elapsed >= per - 1);
      if (EN) m_elapsed = tick ? 0 : m_elapsed + 1;
      m_wrap = 0;
      if (tick) begin
        case (MODE)
          2'd0: begin
            if (!DIR) begin m_wrap = (m_ptr == M - 1); m_ptr = (m_ptr + 1) % M; end
            else      begin m_wrap = (m_ptr == 0);     m_ptr = (m_ptr + M - 1) % M; end
          end
          2'd1: begin
            if (M == N) begin m_ptr = 0; m_wrap = 1; end
            else if (m_fwd && m_ptr >= M - N) begin m_fwd = 1'b0; m_ptr--; m_wrap = 1; end
            else if (!m_fwd && m_ptr == 0) begin m_fwd = 1'b1; m_ptr++; m_wrap = 1; end
            else if (m_fwd) m_ptr++;
            else m_ptr--;
          end
          2'd3: m_visible = !m_visible;
          default: ;
        endcase
      end
      if (MODE != 2'd3) m_visible = 1'b1;
      m_rdy = (!EN || MODE == 2'd2) ? 1 : 0;
      m_rdy_known = 1'b1;
    end
    if (m_live) begin
      e.an = m_an; e.disp = m_disp; e.pos = m_ptr; e.wrap = m_wrap;
      e.rdy = m_rdy; e.rdy_known = m_rdy_known;
      exp_q.push_back(e);
    end
  end

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("AN", int'(AN), e.an);
      chk("DISP", int'(DISP), e.disp);
      chk("POS", int'(POS), e.pos);
      chk("WRAP", int'(WRAP), e.wrap);
      if (e.rdy_known) chk("LD_READY", int'(ld_if.LD_READY), e.rdy);
    end
  end

  // Called at a negedge; holds LD_VALID until seen ready, ends at a negedge
  task automatic load(input int idx, input logic [6:0] ch);
    int n = 0;
    bit done = 1'b0;
    ld_if.LD_VALID = 1'b1;
    ld_if.LD_INDEX = 3'(idx);
    ld_if.LD_CHAR  = ch;
    while (!done && n < 50) begin
      if (ld_if.LD_READY) done = 1'b1;
      @(negedge CLK);
      n++;
    end
    ld_if.LD_VALID = 1'b0;
    chk("load accepted", int'(done), 1);
  endtask

  task automatic wait_an(input logic [3:0] want);
    int n = 0;
    while (AN !== want && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("wait AN", int'(AN), int'(want));
  endtask

  logic [3:0] an_tbl [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  int wraps, stray, n;

  initial begin
    RST = 1'b1; EN = 1'b0; DIR = 1'b0; MODE = 2'd2; SPEED = 2'd0;
    ld_if.LD_VALID = 1'b0; ld_if.LD_INDEX = 3'd0; ld_if.LD_CHAR = 7'd0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // 1: load 01..06 with EN=0, then one full scan of the window at ptr=0
    for (int i = 0; i < M; i++) load(i, 7'(i + 1));
    wait_an(an_tbl[0]);
    chk("S1 DISP", int'(DISP), 1);
    for (int k = 1; k < 4; k++) begin
      repeat (2) @(negedge CLK);
      chk("S1 AN", int'(AN), int'(an_tbl[k]));
      chk("S1 DISP", int'(DISP), k + 1);
    end
    chk("S1 POS", int'(POS), 0);

    // 2: rotate forward six steps, then one step backward
    MODE = 2'd0; DIR = 1'b0; SPEED = 2'd0; EN = 1'b1; wraps = 0;
    repeat (24) begin @(negedge CLK); if (WRAP) wraps++; end
    chk("S2 wraps fwd", wraps, 1);
    chk("S2 POS fwd", int'(POS), 0);
    DIR = 1'b1; wraps = 0;
    repeat (4) begin @(negedge CLK); if (WRAP) wraps++; end
    chk("S2 wraps back", wraps, 1);
    chk("S2 POS back", int'(POS), 5);
    repeat (40) begin @(negedge CLK); DIR = 1'($urandom); end

    // 3: bounce at period 8
    MODE = 2'd1; SPEED = 2'd1;
    repeat (80) @(negedge CLK);

    // 4: blink, then hold
    MODE = 2'd3; SPEED = 2'd0;
    repeat (40) @(negedge CLK);
    MODE = 2'd2;
    @(negedge CLK);
    chk("S4 ready", int'(ld_if.LD_READY), 1);
    repeat (8) @(negedge CLK);

    // 5: freeze mid-period, resume, then out-of-range writes
    MODE = 2'd0; EN = 1'b1;
    repeat (6) @(negedge CLK);
    EN = 1'b0;
    repeat (10) @(negedge CLK);
    EN = 1'b1;
    repeat (8) @(negedge CLK);
    EN = 1'b0;
    @(negedge CLK);
    load(7, 7'h55);
    load(6, 7'h2A);
    stray = 0;
    repeat (16) begin @(negedge CLK); if (DISP == 7'h55 || DISP == 7'h2A) stray++; end
    chk("S5 stray", stray, 0);

    // random soak
    repeat (300) begin
      @(negedge CLK);
      EN = ($urandom_range(0, 3) != 0);
      DIR = 1'($urandom);
      if ($urandom_range(0, 15) == 0) MODE = 2'($urandom);
      if ($urandom_range(0, 15) == 0) SPEED = 2'($urandom);
      ld_if.LD_VALID = 1'($urandom);
      ld_if.LD_INDEX = 3'($urandom_range(0, 7));
      ld_if.LD_CHAR  = 7'($urandom);
    end
    @(negedge CLK);
    ld_if.LD_VALID = 1'b0;

    // 6: reset mid-rotate at POS=3
    MODE = 2'd0; SPEED = 2'd0; DIR = 1'b0; EN = 1'b1;
    n = 0;
    while (POS !== 3'd3 && n < 100) begin @(negedge CLK); n++; end
    chk("S6 reach POS3", int'(POS), 3);
    RST = 1'b1;
    @(negedge CLK);
    chk("S6 POS", int'(POS), 0);
    chk("S6 AN", int'(AN), 'hF);
    chk("S6 DISP", int'(DISP), 'h7F);
    chk("S6 WRAP", int'(WRAP), 0);
    RST = 1'b0; EN = 1'b0;
    repeat (10) begin @(negedge CLK); chk("S6 blank buf", int'(DISP), 'h7F); end

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/marquee_scroll_param.md
Name: marquee_scroll_param

Overview:
Parametrised multiplexed 7-segment marquee. It holds a writable message buffer of MSG_CHARS characters and drives a NUM_DIGITS-wide window of that buffer onto a time-multiplexed common-anode display. It supports four modes (rotate, bounce, hold, blink), a direction control, and four runtime step rates. It replaces the fixed 8-character/4-digit scroller at the board top level.

Parameters:
NUM_DIGITS, 4, number of display digits (≥1)
MSG_CHARS, 8, message buffer depth in characters (≥ NUM_DIGITS)
SEG_W, 7, segment bits per character, active-low
TICK_DIV, 12500000, clock cycles per step unit
REFRESH_DIV, 250000, clock cycles per digit scan slot
BLANK, all-ones (SEG_W bits), blank character pattern

Ports:
CLK  in  1  system clock; all logic on posedge
RST  in  1  synchronous, active-high reset
EN  in  1  1 = stepping enabled; 0 = step counter and window frozen
DIR  in  1  rotate mode only: 0 = window advances (ptr+1), 1 = window retreats (ptr−1)
MODE  in  2  00 rotate, 01 bounce, 10 hold, 11 blink
SPEED  in  2  step period = (SPEED+1)*TICK_DIV cycles
LD_VALID  in  1  write request
LD_READY  out  1  write can be accepted
LD_INDEX  in  clog2(MSG_CHARS)  buffer slot to write
LD_CHAR  in  SEG_W  character pattern
DISP  out  SEG_W  segment drive, active-low
AN  out  NUM_DIGITS  digit enables, active-low, one-cold
POS  out  clog2(MSG_CHARS)  current window pointer ptr
WRAP  out  1  one-cycle pulse on wrap or bounce reversal

Behaviour:
- Reset state (next edge with RST=1): buffer all BLANK; ptr=0; step counter=0; scan counter=0; scan digit=NUM_DIGITS-1; bounce direction=forward; blink phase=visible; DISP=BLANK; AN=all ones; WRAP=0. RST overrides all other inputs.
- Window mapping: digit i (0 = rightmost) shows buf[(ptr + NUM_DIGITS-1-i) mod MSG_CHARS]. The leftmost digit therefore shows buf[ptr].
- Step counter: increments while EN=1 and holds while EN=0.
  - A tick fires when counter ≥ period−1; the counter then clears.
  - Lowering SPEED mid-period, with counter already ≥ the new period−1, fires the tick on the next enabled cycle.
- On each tick:
  - Rotate: ptr = (ptr±1) mod MSG_CHARS. WRAP=1 on the MSG_CHARS−1→0 transition (DIR=0) or the 0→MSG_CHARS−1 transition (DIR=1).
  - Bounce: ptr ranges over 0..MSG_CHARS−NUM_DIGITS. Forward increments and backward decrements. At an end stop, the tick reverses direction and moves one step, and WRAP=1 on that tick. If MSG_CHARS==NUM_DIGITS, ptr stays 0 and WRAP pulses on every tick. DIR is ignored.
  - Hold: ptr unchanged; no WRAP.
  - Blink: ptr unchanged; blink phase toggles. In the blank phase every digit shows BLANK, and AN keeps scanning.
- Leaving blink mode forces the phase back to visible on the next cycle.
- Mode changes take effect at the next tick. The bounce direction flag persists across mode changes.
- Load handshake:
  - LD_READY = (EN==0) or (MODE==hold), registered, and it reflects inputs from the previous cycle.
  - A write occurs on a cycle with LD_VALID & LD_READY. The new char is visible at the next scan slot that reads that index.
  - LD_VALID with LD_READY=0 is ignored, and the requester must hold it.
  - An out-of-range LD_INDEX (≥ MSG_CHARS) is accepted and discarded.
- Scan:
  - The scan counter counts 0..REFRESH_DIV−1, independent of EN.
  - At terminal count, scan digit moves to the next lower digit, wrapping from 0 to NUM_DIGITS−1.
  - AN and DISP are registered together on that edge. AN has a single 0 at the scan digit position; DISP is the mapped character or BLANK.
  - Until the first scan slot after reset, AN=all ones.
- A ptr update and a scan update on the same edge: the scan uses the pre-update ptr, and the new ptr is seen from the next slot.
- A write and a tick on the same cycle are impossible in rotate/bounce because LD_READY=0 there. In hold/blink, both complete independently.

Test Plan:
Bench parameters for all scenarios: NUM_DIGITS=4, MSG_CHARS=6, TICK_DIV=4, REFRESH_DIV=2.
1. Reset, then load buf[0..5]=0x01..0x06 with EN=0 → each write is accepted on the LD_READY=1 cycle. Over 4 scan slots AN=0111,1011,1101,1110 with DISP=01,02,03,04. POS=0.
2. Rotate, DIR=0, SPEED=0, EN=1 → POS steps every 4 cycles: 1,2,3,4,5,0. WRAP pulses exactly once, on the 5→0 step. At POS=4 the leftmost digit shows 05, then 06,01,02. DIR=1 from POS=0 → POS=5 with a WRAP pulse.
3. Bounce, SPEED=1 (period 8) → POS sequence 0,1,2,1,0,1. WRAP pulses at the 2→1 and 0→1 steps only.
4. Blink → POS is frozen. Every 4 cycles, all DISP values alternate with BLANK (0x7F) while AN keeps scanning. Switching to hold → visible again at the next cycle; LD_READY=1 one cycle later.
5. EN=0 at counter=2 for 10 cycles, then EN=1 → the tick fires 1 enabled cycle after resume, not 4. With LD_VALID held, LD_INDEX=7 → accepted, and no buffer slot changes.
6. RST asserted mid-rotate with POS=3 → on the next edge POS=0, AN=1111, DISP=0x7F, buffer all BLANK, WRAP=0.
